aud_i2s_tx: RTL and testbench

AUD_I2S_TX -- requirements
Module: aud_i2s_tx

---
 rtl/aud_pkg.sv | 14 +
 rtl/aud_sample_fifo.sv | 49 ++++
 rtl/aud_i2s_tx.sv | 156 +++++++++++++++
 tb/tb_aud_i2s_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// Shared types and constants for the I2S audio transmitter.
package aud_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } aud_state_e;

  // Channel encoding of the frame clock.
  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/aud_sample_fifo.sv
// Stereo sample-pair FIFO clocked on the falling bit clock.
// Pointers carry one extra wrap bit so full and empty are told apart by the level.
module aud_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       bclk,
  input  logic                       i_rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  always_ff @(negedge bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(negedge bclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/aud_i2s_tx.sv
// I2S transmitter: buffers stereo pairs and serialises them MSB first,
// one bit clock after each frame-clock transition.
//
// state | meaning
// IDLE  | output low, waiting for a left edge with enable set
// SHIFT | driving word bits, one per falling bit clock
// PAD   | word complete, output low until the next slot edge
module aud_i2s_tx
  import aud_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_bclk,
  input  logic                          i_rst_n,
  input  logic                          i_daclrck,
  input  logic                          i_en,
  input  logic                          i_mono,
  input  logic                          i_valid,
  input  logic [DATA_W-1:0]             i_data_l,
  input  logic [DATA_W-1:0]             i_data_r,
  output logic                          o_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_underrun,
  input  logic                          i_clr_underrun,
  output logic                          o_aud_dacdat
);

  localparam int CW = $clog2(DATA_W + 1);

  aud_state_e        state_q, state_d;
  logic              lrck_q;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              dac_q, dac_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic [DATA_W-1:0] hold_r_q, hold_r_d;
  logic              underrun_q, underrun_d;
  logic              left_edge, right_edge;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_l, fifo_r;
  logic              load;
  logic [DATA_W-1:0] word;

  assign left_edge    = (i_daclrck != lrck_q) && (i_daclrck == LEFT);
  assign right_edge   = (i_daclrck != lrck_q) && (i_daclrck == RIGHT);
  assign o_ready      = !fifo_full;
  assign o_underrun   = underrun_q;
  assign o_aud_dacdat = dac_q & i_en;

  aud_sample_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .bclk    (i_bclk),
    .i_rst_n (i_rst_n),
    .push    (i_valid),
    .wdata   ({i_data_l, i_data_r}),
    .pop     (fifo_pop),
    .rdata   ({fifo_l, fifo_r}),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_level)
  );

  // Next-state, shifter and underrun decisions for the current bit clock.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    dac_d      = dac_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    underrun_d = underrun_q;
    fifo_pop   = 1'b0;
    load       = 1'b0;
    word       = '0;

    if (i_clr_underrun) underrun_d = 1'b0;

    if (!i_en) begin
      state_d = IDLE;
      dac_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          dac_d = 1'b0;
          load  = left_edge;
        end
        SHIFT, PAD: begin
          if (left_edge || right_edge) begin
            load = 1'b1;
          end else if (state_q == SHIFT) begin
            if (cnt_q < CW'(DATA_W - 1)) begin
              dac_d = sh_q[DATA_W-1];
              sh_d  = {sh_q[DATA_W-2:0], 1'b0};
              cnt_d = cnt_q + 1'b1;
            end else begin
              state_d = PAD;
              dac_d   = 1'b0;
              cnt_d   = CW'(DATA_W);
            end
          end else begin
            dac_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          dac_d   = 1'b0;
        end
      endcase

      // A left edge fetches a new pair; an empty FIFO sends silence and flags it.
      if (load && left_edge) begin
        fifo_pop = !fifo_empty;
        hold_l_d = fifo_empty ? '0 : fifo_l;
        hold_r_d = fifo_empty ? '0 : fifo_r;
        if (fifo_empty) underrun_d = 1'b1;
        word = hold_l_d;
      end else if (load) begin
        word = i_mono ? hold_l_q : hold_r_q;
      end

      if (load) begin
        state_d = SHIFT;
        dac_d   = word[DATA_W-1];
        sh_d    = {word[DATA_W-2:0], 1'b0};
        cnt_d   = '0;
      end
    end
  end

  // State and datapath registers on the falling bit clock.
  always_ff @(negedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      lrck_q     <= 1'b1;
      sh_q       <= '0;
      cnt_q      <= '0;
      dac_q      <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lrck_q     <= i_daclrck;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      dac_q      <= dac_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_aud_i2s_tx.sv
// Directed bench for aud_i2s_tx: a 16-bit instance for framing, FIFO and reset
// behaviour, and a 24-bit instance run with 16-bclk slots for truncation.
module tb_aud_i2s_tx;

  logic bclk = 1'b1;
  always #5 bclk = ~bclk;

  logic        rst_n, daclrck, en, mono, valid, clr;
  logic [15:0] dl, dr;
  logic        ready, underrun, dac;
  logic [2:0]  level;

  logic        rst24_n, en24, valid24, ready24, underrun24, dac24;
  logic [23:0] dl24, dr24;
  logic [2:0]  level24;

  logic [31:0] cap16, cap24;
  int total = 0;
  int bad   = 0;

  aud_i2s_tx #(.DATA_W(16), .FIFO_DEPTH(4)) u_dut (
    .i_bclk(bclk), .i_rst_n(rst_n), .i_daclrck(daclrck), .i_en(en),
    .i_mono(mono), .i_valid(valid), .i_data_l(dl), .i_data_r(dr),
    .o_ready(ready), .o_level(level), .o_underrun(underrun),
    .i_clr_underrun(clr), .o_aud_dacdat(dac)
  );

  aud_i2s_tx #(.DATA_W(24), .FIFO_DEPTH(4)) u_dut24 (
    .i_bclk(bclk), .i_rst_n(rst24_n), .i_daclrck(daclrck), .i_en(en24),
    .i_mono(1'b0), .i_valid(valid24), .i_data_l(dl24), .i_data_r(dr24),
    .o_ready(ready24), .o_level(level24), .o_underrun(underrun24),
    .i_clr_underrun(1'b0), .o_aud_dacdat(dac24)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge bclk);
    @(posedge bclk);
  endtask

  task automatic push16(input logic [15:0] l, input logic [15:0] r);
    valid = 1'b1; dl = l; dr = r;
    tick();
    valid = 1'b0;
  endtask

  // One slot of len bit clocks; captures both serial outputs, optional push in first cycle.
  task automatic slot(input logic ch, input int len, input logic pv,
                      input logic [15:0] pl, input logic [15:0] pr);
    daclrck = ch;
    cap16 = '0;
    cap24 = '0;
    for (int i = 0; i < len; i++) begin
      if (i == 0 && pv) begin
        valid = 1'b1; dl = pl; dr = pr;
      end
      tick();
      valid = 1'b0;
      cap16 = {cap16[30:0], dac};
      cap24 = {cap24[30:0], dac24};
    end
  endtask

  initial begin
    rst_n = 1'b0; rst24_n = 1'b0; daclrck = 1'b1; en = 1'b0; mono = 1'b0;
    valid = 1'b0; clr = 1'b0; dl = '0; dr = '0;
    en24 = 1'b0; valid24 = 1'b0; dl24 = '0; dr24 = '0;
    repeat (3) @(posedge bclk);
    chk("rst_ready", ready, 1);
    chk("rst_level", level, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_dac", dac, 0);
    rst_n = 1'b1; rst24_n = 1'b1;

    // Basic stereo frame
    en = 1'b1;
    push16(16'hA5F0, 16'h0F5A);
    chk("push_level", level, 1);
    slot(1'b0, 32, 1'b0, 16'h0, 16'h0);
    chk("frame_left", cap16, 32'hA5F0_0000);
    chk("pop_level", level, 0);
    slot(1'b1, 32, 1'b0, 16'h0, 16'h0);
    chk("frame_right", cap16, 32'h0F5A_0000);

    // Mono: left sample in both slots
    mono = 1'b1;
    push16(16'h8001, 16'hFFFF);
    slot(1'b0, 32, 1'b0, 16'h0, 16'h0);
    chk("mono_left", cap16, 32'h8001_0000);
    slot(1'b1, 32, 1'b0, 16'h0, 16'h0);
    chk("mono_right", cap16, 32'h8001_0000);
    mono = 1'b0;

    // Underrun, sticky flag, clear, set-over-clear
    chk("underrun_before", underrun, 0);
    slot(1'b0, 32, 1'b0, 16'h0, 16'h0);
    chk("underrun_left", cap16, 32'h0);
    chk("underrun_set", underrun, 1);
    slot(1'b1, 32, 1'b0, 16'h0, 16'h0);
    chk("underrun_right", cap16, 32'h0);
    chk("underrun_sticky", underrun, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("underrun_clr", underrun, 0);
    clr = 1'b1; daclrck = 1'b0;
    tick();
    chk("underrun_set_wins", underrun, 1);
    clr = 1'b0;
    slot(1'b0, 31, 1'b0, 16'h0, 16'h0);

    // FIFO fill with transmit disabled
    en = 1'b0;
    tick();
    push16(16'h1234, 16'h5678);
    chk("fill_level1", level, 1);
    push16(16'hFFFF, 16'h0001);
    chk("fill_level2", level, 2);
    push16(16'hC3C3, 16'h3C3C);
    chk("fill_level3", level, 3);
    chk("fill_ready3", ready, 1);
    push16(16'h0F0F, 16'hF0F0);
    chk("fill_level4", level, 4);
    chk("fill_ready4", ready, 0);
    push16(16'hDEAD, 16'hBEEF);
    chk("fill_level5", level, 4);

    en = 1'b1;
    slot(1'b1, 32, 1'b0, 16'h0, 16'h0);
    chk("idle_right_ignored", cap16, 32'h0);
    slot(1'b0, 32, 1'b1, 16'h7777, 16'h8888);
    chk("full_pop_left", cap16, 32'h1234_0000);
    chk("full_push_blocked", level, 3);
    slot(1'b1, 32, 1'b0, 16'h0, 16'h0);
    chk("full_pop_right", cap16, 32'h5678_0000);
    slot(1'b0, 32, 1'b1, 16'h7777, 16'h8888);
    chk("pushpop_left", cap16, 32'hFFFF_0000);
    chk("pushpop_level", level, 3);
    slot(1'b1, 32, 1'b0, 16'h0, 16'h0);
    chk("pushpop_right", cap16, 32'h0001_0000);

    // Enable gating and reset mid-left-slot
    daclrck = 1'b0;
    tick();
    tick();
    chk("midslot_dac", dac, 1);
    chk("midslot_level", level, 2);
    en = 1'b0;
    #1;
    chk("en_gate_dac", dac, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_dac", dac, 0);
    chk("mrst_level", level, 0);
    chk("mrst_ready", ready, 1);
    chk("mrst_underrun", underrun, 0);
    en = 1'b1;
    daclrck = 1'b1;
    tick();
    rst_n = 1'b1;
    slot(1'b1, 32, 1'b0, 16'h0, 16'h0);
    chk("post_rst_right", cap16, 32'h0);
    slot(1'b0, 32, 1'b0, 16'h0, 16'h0);
    chk("post_rst_left", cap16, 32'h0);
    chk("post_rst_underrun", underrun, 1);
    chk("post_rst_level", level, 0);

    // 24-bit words in 16-bclk slots: truncation
    valid24 = 1'b1; dl24 = 24'hFFFFFF; dr24 = 24'hABCDEF; en24 = 1'b1;
    tick();
    valid24 = 1'b0;
    chk("w24_level", level24, 1);
    slot(1'b1, 16, 1'b0, 16'h0, 16'h0);
    chk("w24_idle", cap24, 32'h0);
    slot(1'b0, 16, 1'b0, 16'h0, 16'h0);
    chk("w24_left", cap24, 32'h0000_FFFF);
    chk("w24_pop", level24, 0);
    slot(1'b1, 16, 1'b0, 16'h0, 16'h0);
    chk("w24_right", cap24, 32'h0000_ABCD);
    slot(1'b0, 16, 1'b0, 16'h0, 16'h0);
    chk("w24_underrun_data", cap24, 32'h0);
    chk("w24_underrun", underrun24, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
